frame_scheduler: RTL and testbench

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

---
 rtl/frame_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_frame_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - per-frame erase/draw sequencer for three sprite channels
//
// Purpose:
//    Once per frame tick (when enabled and idle) walks the three sprite
//    channels (0 player, 1 bullet, 2 alien). If a previous frame has been
//    drawn, each channel is first erased for ERASE_CYCLES cycles, then each
//    channel is asked to draw until its engine reports finish or
//    DRAW_TIMEOUT cycles pass. A one-cycle gap with no request separates
//    every channel step.
//
// Ports:
//    clk           system clock, rising edge
//    reset         synchronous, active-low
//    enable        1 = a frame tick may start a frame
//    finish[2:0]   per-channel draw-complete from the sprite engines
//    ch_x/ch_y     packed 9-bit / 8-bit coordinates, channel i in slice i
//    ch_colour     packed 3-bit colours, channel i in slice i
//    draw_signal   one-hot level draw request
//    erase_signal  one-hot level erase request
//    vga_x/vga_y/vga_colour/plot   pixel write to the VGA adapter
//    frame_done    one-cycle pulse in the final draw gap of a frame
//    timeout_err   sticky, set when a channel never finished in time
`timescale 1ns/1ps
module frame_scheduler #(
   parameter int FRAME_CYCLES = 833333,
   parameter int ERASE_CYCLES = 48,
   parameter int DRAW_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [2:0]  finish,
   input  logic [26:0] ch_x,
   input  logic [23:0] ch_y,
   input  logic [8:0]  ch_colour,
   output logic [2:0]  draw_signal,
   output logic [2:0]  erase_signal,
   output logic [8:0]  vga_x,
   output logic [7:0]  vga_y,
   output logic [2:0]  vga_colour,
   output logic        plot,
   output logic        frame_done,
   output logic        timeout_err
);

   localparam int FW   = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam int MAXC = (ERASE_CYCLES > DRAW_TIMEOUT) ? ERASE_CYCLES : DRAW_TIMEOUT;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
   localparam logic [CW-1:0] ERASE_LAST = CW'(ERASE_CYCLES - 1);
   localparam logic [CW-1:0] DRAW_LAST  = CW'(DRAW_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERASE,
      S_ERASE_GAP,
      S_DRAW,
      S_DRAW_GAP
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      ch_q, ch_d;
   logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
   logic [CW-1:0]   cyc_q, cyc_d;
   logic            drawn_q, drawn_d;
   logic            timeout_err_q, timeout_err_d;
   logic [2:0]      draw_q, draw_d;
   logic [2:0]      erase_q, erase_d;
   logic            plot_q, plot_d;
   logic            frame_done_q, frame_done_d;

   logic            tick;
   logic            fin_sel;
   logic [2:0]      ch_onehot_d;
   logic [8:0]      sel_x;
   logic [7:0]      sel_y;
   logic [2:0]      sel_colour;

   // Active-channel selection; channel index 3 is never reached.
   always_comb begin
      fin_sel    = 1'b0;
      sel_x      = '0;
      sel_y      = '0;
      sel_colour = '0;
      case (ch_q)
         2'd0: begin
            fin_sel    = finish[0];
            sel_x      = ch_x[8:0];
            sel_y      = ch_y[7:0];
            sel_colour = ch_colour[2:0];
         end
         2'd1: begin
            fin_sel    = finish[1];
            sel_x      = ch_x[17:9];
            sel_y      = ch_y[15:8];
            sel_colour = ch_colour[5:3];
         end
         2'd2: begin
            fin_sel    = finish[2];
            sel_x      = ch_x[26:18];
            sel_y      = ch_y[23:16];
            sel_colour = ch_colour[8:6];
         end
         default: begin
            fin_sel    = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_d       = state_q;
      ch_d          = ch_q;
      cyc_d         = cyc_q;
      drawn_d       = drawn_q;
      timeout_err_d = timeout_err_q;

      tick        = (frame_cnt_q == FRAME_LAST);
      frame_cnt_d = tick ? '0 : frame_cnt_q + FW'(1);

      case (state_q)
         S_IDLE: begin
            // Ticks are only honoured here; any tick while busy is lost.
            if (tick && enable) begin
               ch_d    = 2'd0;
               cyc_d   = '0;
               state_d = drawn_q ? S_ERASE : S_DRAW;
            end
         end
         S_ERASE: begin
            if (cyc_q == ERASE_LAST) begin
               state_d = S_ERASE_GAP;
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         S_ERASE_GAP: begin
            cyc_d = '0;
            if (ch_q == 2'd2) begin
               ch_d    = 2'd0;
               state_d = S_DRAW;
            end else begin
               ch_d    = ch_q + 2'd1;
               state_d = S_ERASE;
            end
         end
         S_DRAW: begin
            // finish is sampled every DRAW cycle, including the first one.
            if (fin_sel) begin
               state_d = S_DRAW_GAP;
            end else if (cyc_q == DRAW_LAST) begin
               state_d       = S_DRAW_GAP;
               timeout_err_d = 1'b1;
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         S_DRAW_GAP: begin
            cyc_d = '0;
            if (ch_q == 2'd2) begin
               ch_d    = 2'd0;
               drawn_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               ch_d    = ch_q + 2'd1;
               state_d = S_DRAW;
            end
         end
         default: begin
            state_d = S_IDLE;
            ch_d    = 2'd0;
         end
      endcase

      // Outputs are decoded from the next state so they are registered
      // alongside it and change on the same edge.
      ch_onehot_d  = 3'b001 << ch_d;
      draw_d       = (state_d == S_DRAW)  ? ch_onehot_d : 3'b000;
      erase_d      = (state_d == S_ERASE) ? ch_onehot_d : 3'b000;
      plot_d       = (state_d == S_DRAW) || (state_d == S_ERASE);
      frame_done_d = (state_d == S_DRAW_GAP) && (ch_d == 2'd2);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         ch_q          <= 2'd0;
         frame_cnt_q   <= '0;
         cyc_q         <= '0;
         drawn_q       <= 1'b0;
         timeout_err_q <= 1'b0;
         draw_q        <= 3'b000;
         erase_q       <= 3'b000;
         plot_q        <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         ch_q          <= ch_d;
         frame_cnt_q   <= frame_cnt_d;
         cyc_q         <= cyc_d;
         drawn_q       <= drawn_d;
         timeout_err_q <= timeout_err_d;
         draw_q        <= draw_d;
         erase_q       <= erase_d;
         plot_q        <= plot_d;
         frame_done_q  <= frame_done_d;
      end
   end

   // Pixel bus is forced to zero when not plotting; erase writes black.
   assign draw_signal  = draw_q;
   assign erase_signal = erase_q;
   assign plot         = plot_q;
   assign frame_done   = frame_done_q;
   assign timeout_err  = timeout_err_q;
   assign vga_x        = plot_q ? sel_x : 9'd0;
   assign vga_y        = plot_q ? sel_y : 8'd0;
   assign vga_colour   = (draw_q != 3'b000) ? sel_colour : 3'b000;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - scoreboard bench for frame_scheduler
`timescale 1ns/1ps
module tb_frame_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [2:0]  finish = 3'b000;
   logic [26:0] ch_x;
   logic [23:0] ch_y;
   logic [8:0]  ch_colour;
   logic [2:0]  draw_signal;
   logic [2:0]  erase_signal;
   logic [8:0]  vga_x;
   logic [7:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        plot;
   logic        frame_done;
   logic        timeout_err;

   always #5 clk = ~clk;

   frame_scheduler #(
      .FRAME_CYCLES(100),
      .ERASE_CYCLES(48),
      .DRAW_TIMEOUT(64)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .finish(finish),
      .ch_x(ch_x),
      .ch_y(ch_y),
      .ch_colour(ch_colour),
      .draw_signal(draw_signal),
      .erase_signal(erase_signal),
      .vga_x(vga_x),
      .vga_y(vga_y),
      .vga_colour(vga_colour),
      .plot(plot),
      .frame_done(frame_done),
      .timeout_err(timeout_err)
   );

   // kind: 0 erase, 1 draw, 2 frame_done
   typedef struct {
      int kind;
      int ch;
      int start;
      int len;
   } ev_t;

   ev_t exp_q[$];
   int  errors = 0;
   int  checks = 0;
   int  cyc = 0;
   int  t = 0;

   // cyc counts edges since reset release; t never restarts.
   always @(posedge clk) begin
      t++;
      if (!reset) cyc = 0;
      else cyc++;
   end

   // Sprite engine model: finish 43 cycles into a draw, optional masks.
   int         dc [3] = '{0, 0, 0};
   logic [2:0] fin_en = 3'b111;
   logic [2:0] noise = 3'b000;
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (draw_signal[i]) dc[i]++;
         else dc[i] = 0;
         finish[i] = noise[i] | (draw_signal[i] && (dc[i] >= 43) && fin_en[i]);
      end
   end

   task automatic push_ev(input int kind, input int ch, input int start, input int len);
      ev_t e;
      e.kind = kind; e.ch = ch; e.start = start; e.len = len;
      exp_q.push_back(e);
   endtask

   task automatic push_frame(input int s, input bit er, input int l0, input int l1, input int l2);
      int c;
      int l [3];
      l[0] = l0; l[1] = l1; l[2] = l2;
      c = s;
      if (er) begin
         for (int i = 0; i < 3; i++) begin
            push_ev(0, i, c, 48);
            c += 49;
         end
      end
      for (int i = 0; i < 3; i++) begin
         push_ev(1, i, c, l[i]);
         c += l[i] + 1;
      end
      push_ev(2, 0, c - 1, 0);
   endtask

   task automatic emit(input int kind, input int ch, input int start, input int len);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL event: unexpected kind=%0d ch=%0d start=%0d len=%0d", kind, ch, start, len);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.ch != ch || e.start != start || e.len != len) begin
            errors++;
            $display("FAIL event: got kind=%0d ch=%0d start=%0d len=%0d, want kind=%0d ch=%0d start=%0d len=%0d",
                     kind, ch, start, len, e.kind, e.ch, e.start, e.len);
         end
      end
   endtask

   function automatic int idx3(input logic [2:0] v);
      if (v[0]) return 0;
      if (v[1]) return 1;
      return 2;
   endfunction

   // Monitor: turns request windows and frame_done pulses into events and
   // checks the pixel bus every cycle a request is active.
   logic [5:0] prev_req = 6'd0;
   int         st_cyc = 0;
   int         st_t = 0;
   always @(negedge clk) begin
      logic [5:0]  req;
      logic [20:0] got_pix, exp_pix;
      int          a;
      req = {erase_signal, draw_signal};
      if (reset) begin
         checks++;
         got_pix = {plot, vga_x, vga_y, vga_colour};
         if (req == 6'd0) begin
            exp_pix = {1'b0, got_pix[19:0]};
         end else begin
            a = (draw_signal != 3'b000) ? idx3(draw_signal) : idx3(erase_signal);
            exp_pix = {1'b1, ch_x[9*a +: 9], ch_y[8*a +: 8],
                       (draw_signal != 3'b000) ? ch_colour[3*a +: 3] : 3'b000};
         end
         if ($countones(req) > 1 || got_pix != exp_pix) begin
            errors++;
            $display("FAIL pixel: cyc=%0d req=%b got=%h want=%h", cyc, req, got_pix, exp_pix);
         end
      end
      if (req != prev_req) begin
         if (prev_req != 6'd0) begin
            if (prev_req[5:3] != 3'b000) emit(0, idx3(prev_req[5:3]), st_cyc, t - st_t);
            else emit(1, idx3(prev_req[2:0]), st_cyc, t - st_t);
         end
         if (req != 6'd0) begin
            st_cyc = cyc;
            st_t   = t;
         end
      end
      prev_req = req;
      if (frame_done) emit(2, 0, cyc, 0);
   end

   task automatic check_val(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic at_neg(input int c);
      int guard;
      guard = 0;
      @(negedge clk);
      while (cyc != c && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != c) begin
         errors++;
         checks++;
         $display("FAIL wait: cyc=%0d never reached %0d", cyc, c);
      end
   endtask

   task automatic check_all_zero(input string name);
      check_val(name, int'({draw_signal, erase_signal, plot, frame_done, timeout_err,
                            vga_x, vga_y, vga_colour}), 0);
   endtask

   initial begin
      ch_x      = {9'd300, 9'd150, 9'd7};
      ch_y      = {8'd200, 8'd100, 8'd9};
      ch_colour = {3'd5, 3'd3, 3'd6};

      push_frame(100, 1'b0, 43, 43, 43);   // first frame: no erase
      push_frame(300, 1'b1, 43, 43, 43);   // ticks 200 dropped
      push_frame(600, 1'b1, 43, 43, 64);   // channel 2 times out
      push_frame(1100, 1'b1, 43, 1, 1);    // tick 900 busy, 1000 disabled
      for (int i = 0; i < 3; i++) push_ev(0, i, 1300 + 49 * i, 48);
      push_ev(1, 0, 1447, 43);
      push_ev(1, 1, 1491, 10);             // cut short by reset
      push_frame(100, 1'b0, 43, 43, 43);   // after reset: erase skipped

      repeat (3) @(negedge clk);
      check_all_zero("reset_state");
      reset  = 1'b1;
      enable = 1'b1;

      at_neg(250);
      check_val("timeout_err_clear", int'(timeout_err), 0);
      at_neg(590);
      fin_en = 3'b011;
      at_neg(905);
      check_val("timeout_err_set", int'(timeout_err), 1);
      fin_en = 3'b111;
      at_neg(950);
      enable = 1'b0;
      at_neg(1000);
      enable = 1'b1;
      ch_x      = {9'd511, 9'd256, 9'd1};
      ch_y      = {8'd255, 8'd128, 8'd2};
      ch_colour = {3'd7, 3'd1, 3'd2};
      at_neg(1050);
      noise = 3'b110;                      // inactive finish bits held high
      at_neg(1296);
      noise = 3'b000;
      check_val("timeout_err_sticky", int'(timeout_err), 1);
      at_neg(1500);
      reset = 1'b0;
      @(negedge clk);
      check_all_zero("reset_mid_draw");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      at_neg(5);
      check_val("timeout_err_after_reset", int'(timeout_err), 0);
      at_neg(290);
      check_val("events_left", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
